inst_fetch: RTL and testbench

- Instruction fetch stage. It produces the pc/instruction pair that the decode stage consumes on its pc_i/inst_i inputs.
- Issues in-order word requests to instruction memory and buffers the returned words in a small prefetch FIFO.
- Presents one registered instruction per cycle to decode, and honours pipeline stall and branch/exception redirect (flush).
- When no valid instruction is available, it outputs the all-zero word, which decode treats as NOP.

---
 rtl/inst_fetch_pkg.sv | 39 +++
 rtl/inst_fetch_if.sv | 36 +++
 rtl/fetch_fifo.sv | 79 +++++++
 rtl/inst_fetch.sv | 134 +++++++++++++
 tb/tb_inst_fetch.sv | 295 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/inst_fetch_pkg.sv
// ----------------------------------------------------------------------------
// inst_fetch_pkg
//   Shared definitions for the instruction fetch stage.
//   - InstBus / InstAddrBus : instruction and instruction-address bus widths
//   - ImemAddrW / ImemDataW : instruction memory handshake bus widths
//   - ZeroWord              : all-zero word, which decode treats as NOP
//   - ResetPC               : default first fetch address after reset
//   - fetch_entry_t         : {pc, inst} pair held by the prefetch FIFO
// ----------------------------------------------------------------------------
package inst_fetch_pkg;

   localparam int InstBus     = 32;
   localparam int InstAddrBus = 32;

   localparam int ImemAddrW = InstAddrBus;
   localparam int ImemDataW = InstBus;

   typedef logic [InstBus-1:0]     inst_bus_t;
   typedef logic [InstAddrBus-1:0] inst_addr_bus_t;

   localparam inst_bus_t      ZeroWord = '0;
   localparam inst_addr_bus_t ResetPC  = 32'h0000_0000;

   typedef struct packed {
      inst_addr_bus_t pc;
      inst_bus_t      inst;
   } fetch_entry_t;

   // Next sequential word address; wraps 0xFFFF_FFFC -> 0 naturally.
   function automatic inst_addr_bus_t next_pc(inst_addr_bus_t pc);
      return pc + 32'd4;
   endfunction

   // Force a redirect target onto a word boundary.
   function automatic inst_addr_bus_t word_align(inst_addr_bus_t addr);
      return addr & ~32'h0000_0003;
   endfunction

endpackage

// File: rtl/inst_fetch_if.sv
// ----------------------------------------------------------------------------
// inst_fetch_if
//   Instruction memory request/response bus.
//   - imem_req_o    : request valid (fetch -> memory)
//   - imem_addr_o   : word address of the request (fetch -> memory)
//   - imem_gnt_i    : request accepted this cycle (memory -> fetch)
//   - imem_rvalid_i : read data valid, in request order (memory -> fetch)
//   - imem_rdata_i  : read data (memory -> fetch)
//   master modport is the fetch stage, slave modport is the memory.
// ----------------------------------------------------------------------------
interface inst_fetch_if;
   import inst_fetch_pkg::*;

   logic                 imem_req_o;
   logic [ImemAddrW-1:0] imem_addr_o;
   logic                 imem_gnt_i;
   logic                 imem_rvalid_i;
   logic [ImemDataW-1:0] imem_rdata_i;

   modport master (
      output imem_req_o,
      output imem_addr_o,
      input  imem_gnt_i,
      input  imem_rvalid_i,
      input  imem_rdata_i
   );

   modport slave (
      input  imem_req_o,
      input  imem_addr_o,
      output imem_gnt_i,
      output imem_rvalid_i,
      output imem_rdata_i
   );

endinterface

// File: rtl/fetch_fifo.sv
// ----------------------------------------------------------------------------
// fetch_fifo
//   Synchronous prefetch FIFO of {pc, inst} entries.
//   - clk, rst : clock, asynchronous active-low reset
//   - push     : write push_data at the tail
//   - push_data: entry to write
//   - pop      : drop the head entry
//   - clear    : empty the FIFO (wins over push/pop)
//   - count    : number of valid entries
//   - head     : oldest entry (undefined contents while count == 0)
//   Push into a full FIFO is only honoured when a pop happens in the same
//   cycle; the fetch stage never asks for more than that.
// ----------------------------------------------------------------------------
module fetch_fifo
   import inst_fetch_pkg::*;
#(
   parameter  int DEPTH = 2,
   localparam int CntW  = $clog2(DEPTH + 1)
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            push,
   input  fetch_entry_t    push_data,
   input  logic            pop,
   input  logic            clear,
   output logic [CntW-1:0] count,
   output fetch_entry_t    head
);

   localparam int              PtrW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [PtrW-1:0] LastPtr = PtrW'(DEPTH - 1);
   localparam logic [CntW-1:0] Full    = CntW'(DEPTH);

   fetch_entry_t    mem_q [DEPTH];
   logic [PtrW-1:0] wr_ptr;
   logic [PtrW-1:0] rd_ptr;
   logic            do_push;
   logic            do_pop;

   function automatic logic [PtrW-1:0] ptr_inc(logic [PtrW-1:0] p);
      return (p == LastPtr) ? '0 : p + 1'b1;
   endfunction

   assign do_pop  = pop && (count != '0);
   assign do_push = push && ((count != Full) || do_pop);
   assign head    = mem_q[rd_ptr];

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else if (clear) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) begin
            wr_ptr <= ptr_inc(wr_ptr);
         end
         if (do_pop) begin
            rd_ptr <= ptr_inc(rd_ptr);
         end
         if (do_push && !do_pop) begin
            count <= count + 1'b1;
         end else if (do_pop && !do_push) begin
            count <= count - 1'b1;
         end
      end
   end

   // Storage is data-only; validity is tracked by the pointers and count.
   always_ff @(posedge clk) begin
      if (do_push && !clear) begin
         mem_q[wr_ptr] <= push_data;
      end
   end

endmodule

// File: rtl/inst_fetch.sv
// ----------------------------------------------------------------------------
// inst_fetch
//   Instruction fetch stage: issues in-order word requests to instruction
//   memory, buffers the returned words in a prefetch FIFO and presents one
//   registered pc/instruction pair per cycle to decode.
//   - clk, rst      : clock, asynchronous active-low reset
//   - stall_i       : hold pc_o/inst_o/inst_valid_o
//   - flush_i       : redirect, discard all fetched and in-flight work
//   - new_pc_i      : redirect target, sampled while flush_i = 1
//   - imem          : instruction memory bus (inst_fetch_if.master)
//   - pc_o, inst_o  : to decode pc_i / inst_i; zero when nothing is valid
//   - inst_valid_o  : pc_o/inst_o carry a real instruction
//   Parameters: RESET_PC (first fetch address), FIFO_DEPTH (buffer entries,
//   also the cap on in-flight requests plus buffered words, >= 1).
// ----------------------------------------------------------------------------
module inst_fetch
   import inst_fetch_pkg::*;
#(
   parameter inst_addr_bus_t RESET_PC   = ResetPC,
   parameter int             FIFO_DEPTH = 2
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            stall_i,
   input  logic            flush_i,
   input  inst_addr_bus_t  new_pc_i,
   inst_fetch_if.master    imem,
   output inst_addr_bus_t  pc_o,
   output inst_bus_t       inst_o,
   output logic            inst_valid_o
);

   localparam int            CntW = $clog2(FIFO_DEPTH + 1);
   localparam logic [CntW:0] Cap  = (CntW + 1)'(FIFO_DEPTH);

   inst_addr_bus_t  fetch_pc;
   inst_addr_bus_t  resp_pc;
   logic [CntW-1:0] inflight;
   logic [CntW-1:0] discard;
   logic [CntW-1:0] fifo_count;
   logic [CntW:0]   credit_used;
   fetch_entry_t    fifo_head;
   fetch_entry_t    push_entry;
   logic            req;
   logic            accept;
   logic            rsp_ok;
   logic            push;
   logic            pop;

   // Credit is reserved at issue: every in-flight request already owns a
   // FIFO slot, so a response can always be pushed even under stall. A pop
   // in the same cycle is deliberately not credited to keep req off the
   // FIFO read path.
   assign credit_used = {1'b0, inflight} + {1'b0, fifo_count};

   // rst gates the request so the bus stays quiet while reset is held.
   assign req = rst && !flush_i && (credit_used < Cap);

   assign imem.imem_req_o  = req;
   assign imem.imem_addr_o = fetch_pc;

   assign accept = req && imem.imem_gnt_i;
   // A response with nothing outstanding is a protocol error and is ignored.
   assign rsp_ok = imem.imem_rvalid_i && (inflight != '0);
   assign push   = rsp_ok && (discard == '0) && !flush_i;
   assign pop    = !flush_i && !stall_i && (fifo_count != '0);

   assign push_entry = '{pc: resp_pc, inst: imem.imem_rdata_i};

   fetch_fifo #(
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk       (clk),
      .rst       (rst),
      .push      (push),
      .push_data (push_entry),
      .pop       (pop),
      .clear     (flush_i),
      .count     (fifo_count),
      .head      (fifo_head)
   );

   // Request/response bookkeeping. inflight keeps counting requests whose
   // data will be discarded, so discard never exceeds inflight.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         fetch_pc <= RESET_PC;
         resp_pc  <= RESET_PC;
         inflight <= '0;
         discard  <= '0;
      end else if (flush_i) begin
         fetch_pc <= word_align(new_pc_i);
         resp_pc  <= word_align(new_pc_i);
         inflight <= inflight - CntW'(rsp_ok);
         discard  <= inflight - CntW'(rsp_ok);
      end else begin
         if (accept) begin
            fetch_pc <= next_pc(fetch_pc);
         end
         inflight <= inflight + CntW'(accept) - CntW'(rsp_ok);
         if (rsp_ok) begin
            if (discard != '0) begin
               discard <= discard - 1'b1;
            end else begin
               resp_pc <= next_pc(resp_pc);
            end
         end
      end
   end

   // Decode-facing output register: flush > stall > pop > bubble.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         pc_o         <= '0;
         inst_o       <= ZeroWord;
         inst_valid_o <= 1'b0;
      end else if (flush_i) begin
         pc_o         <= '0;
         inst_o       <= ZeroWord;
         inst_valid_o <= 1'b0;
      end else if (!stall_i) begin
         if (pop) begin
            pc_o         <= fifo_head.pc;
            inst_o       <= fifo_head.inst;
            inst_valid_o <= 1'b1;
         end else begin
            pc_o         <= '0;
            inst_o       <= ZeroWord;
            inst_valid_o <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_inst_fetch.sv
module tb_inst_fetch;
   import inst_fetch_pkg::*;

   localparam int DEPTH = 2;

   logic        clk = 1'b0;
   logic        rst;
   logic        stall_i;
   logic        flush_i;
   logic [31:0] new_pc_i;
   logic [31:0] pc_o;
   logic [31:0] inst_o;
   logic        inst_valid_o;

   inst_fetch_if bus ();

   inst_fetch #(
      .RESET_PC   (32'h0000_0000),
      .FIFO_DEPTH (DEPTH)
   ) dut (
      .clk          (clk),
      .rst          (rst),
      .stall_i      (stall_i),
      .flush_i      (flush_i),
      .new_pc_i     (new_pc_i),
      .imem         (bus),
      .pc_o         (pc_o),
      .inst_o       (inst_o),
      .inst_valid_o (inst_valid_o)
   );

   always #5 clk = ~clk;

   // ---------------- memory model and reference model state ----------------
   typedef struct {
      logic [31:0] addr;
      int          due;
      int          epoch;
   } mreq_t;

   typedef struct {
      logic [31:0] pc;
      logic [31:0] inst;
   } word_t;

   typedef struct {
      logic        st;
      logic        fl;
      logic [31:0] np;
      logic        g;
      logic        er;
      logic [31:0] ea;
      logic        ev;
      logic [31:0] ep;
   } vec_t;

   mreq_t       mem_q[$];
   word_t       live_q[$];
   int          epoch;
   logic [31:0] exp_fetch;
   logic        exp_valid;
   logic [31:0] exp_pc;
   logic [31:0] exp_inst;
   int          cyc;
   int          lat_min, lat_max, rv_prob;
   logic        spurious;
   int          n_checks;
   int          n_err;
   vec_t        vt[21];
   logic [31:0] wrap_exp[3];

   function automatic logic [31:0] memf(logic [31:0] a);
      return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
   endfunction

   function automatic vec_t mk(logic st, logic fl, logic [31:0] np, logic g,
                               logic er, logic [31:0] ea, logic ev, logic [31:0] ep);
      vec_t v;
      v.st = st; v.fl = fl; v.np = np; v.g = g;
      v.er = er; v.ea = ea; v.ev = ev; v.ep = ep;
      return v;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic timeout(input string name);
      n_checks++;
      n_err++;
      $display("FAIL %s: timed out waiting (cycle %0d)", name, cyc);
   endtask

   // One clock cycle: drive inputs, check the combinational request against
   // the model, clock, update the model, then check the registered outputs.
   task automatic tick(input logic st, input logic fl, input logic [31:0] np,
                       input logic g, output logic r, output logic [31:0] a);
      logic  rv;
      logic  exp_req;
      int    sz;
      logic  do_pop;
      mreq_t e;
      word_t w;
      int    lat;
      stall_i         = st;
      flush_i         = fl;
      new_pc_i        = np;
      bus.imem_gnt_i  = g;
      rv              = 1'b0;
      if (mem_q.size() > 0) begin
         if (mem_q[0].due <= cyc && $urandom_range(99) < rv_prob) rv = 1'b1;
         bus.imem_rdata_i = memf(mem_q[0].addr);
      end else begin
         if (spurious) rv = 1'b1;
         bus.imem_rdata_i = 32'hDEAD_BEEF;
      end
      spurious          = 1'b0;
      bus.imem_rvalid_i = rv;
      #1;
      r = bus.imem_req_o;
      a = bus.imem_addr_o;
      exp_req = !fl && ((mem_q.size() + live_q.size()) < DEPTH);
      chk("req", 32'(r), 32'(exp_req));
      if (exp_req && r) chk("addr", a, exp_fetch);
      @(posedge clk);
      sz     = live_q.size();
      do_pop = !fl && !st && (sz > 0);
      if (rv && mem_q.size() > 0) begin
         e = mem_q.pop_front();
         if (!fl && e.epoch == epoch) live_q.push_back('{pc: e.addr, inst: memf(e.addr)});
      end
      if (r && g) begin
         lat = $urandom_range(lat_max, lat_min);
         mem_q.push_back('{addr: a, due: cyc + lat, epoch: epoch});
         exp_fetch = exp_fetch + 32'd4;
      end
      if (fl) begin
         epoch++;
         live_q.delete();
         exp_fetch = {np[31:2], 2'b00};
         exp_valid = 1'b0; exp_pc = '0; exp_inst = '0;
      end else if (!st) begin
         if (do_pop) begin
            w = live_q.pop_front();
            exp_valid = 1'b1; exp_pc = w.pc; exp_inst = w.inst;
         end else begin
            exp_valid = 1'b0; exp_pc = '0; exp_inst = '0;
         end
      end
      cyc++;
      @(negedge clk);
      chk("valid", 32'(inst_valid_o), 32'(exp_valid));
      chk("pc", pc_o, exp_pc);
      chk("inst", inst_o, exp_inst);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: no finish by %0t (cycle %0d)", $time, cyc);
      $fatal(1);
   end

   initial begin
      logic        r;
      logic [31:0] a;
      int          held;
      int          got;
      logic        want_hold;
      logic        found;

      n_checks = 0; n_err = 0; cyc = 0;
      lat_min = 1; lat_max = 1; rv_prob = 100; spurious = 1'b0;
      epoch = 0; exp_fetch = 32'h0;
      exp_valid = 1'b0; exp_pc = '0; exp_inst = '0;
      wrap_exp[0] = 32'hFFFF_FFF8; wrap_exp[1] = 32'hFFFF_FFFC; wrap_exp[2] = 32'h0000_0000;

      // st fl np          g  er ea          ev ep
      vt[0]  = mk(0, 0, 32'h0,    1, 1, 32'h0,    0, 32'h0);
      vt[1]  = mk(0, 0, 32'h0,    1, 1, 32'h4,    0, 32'h0);
      vt[2]  = mk(0, 0, 32'h0,    1, 0, 32'h0,    1, 32'h0);
      vt[3]  = mk(0, 0, 32'h0,    1, 1, 32'h8,    1, 32'h4);
      vt[4]  = mk(0, 0, 32'h0,    1, 1, 32'hC,    0, 32'h0);
      vt[5]  = mk(0, 0, 32'h0,    1, 0, 32'h0,    1, 32'h8);
      vt[6]  = mk(0, 0, 32'h0,    1, 1, 32'h10,   1, 32'hC);
      vt[7]  = mk(0, 0, 32'h0,    1, 1, 32'h14,   0, 32'h0);
      vt[8]  = mk(0, 0, 32'h0,    1, 0, 32'h0,    1, 32'h10);
      vt[9]  = mk(0, 0, 32'h0,    1, 1, 32'h18,   1, 32'h14);
      vt[10] = mk(1, 0, 32'h0,    1, 1, 32'h1C,   1, 32'h14);
      vt[11] = mk(1, 0, 32'h0,    1, 0, 32'h0,    1, 32'h14);
      vt[12] = mk(1, 0, 32'h0,    1, 0, 32'h0,    1, 32'h14);
      vt[13] = mk(1, 0, 32'h0,    1, 0, 32'h0,    1, 32'h14);
      vt[14] = mk(1, 0, 32'h0,    1, 0, 32'h0,    1, 32'h14);
      vt[15] = mk(0, 0, 32'h0,    1, 0, 32'h0,    1, 32'h18);
      vt[16] = mk(0, 0, 32'h0,    1, 1, 32'h20,   1, 32'h1C);
      vt[17] = mk(0, 1, 32'h1003, 1, 0, 32'h0,    0, 32'h0);
      vt[18] = mk(0, 0, 32'h0,    1, 1, 32'h1000, 0, 32'h0);
      vt[19] = mk(0, 0, 32'h0,    1, 1, 32'h1004, 0, 32'h0);
      vt[20] = mk(0, 0, 32'h0,    1, 0, 32'h0,    1, 32'h1000);

      rst = 1'b0; stall_i = 1'b0; flush_i = 1'b0; new_pc_i = '0;
      bus.imem_gnt_i = 1'b0; bus.imem_rvalid_i = 1'b0; bus.imem_rdata_i = '0;
      repeat (3) @(negedge clk);
      #1;
      chk("rst_req", 32'(bus.imem_req_o), 32'h0);
      chk("rst_valid", 32'(inst_valid_o), 32'h0);
      chk("rst_pc", pc_o, 32'h0);
      chk("rst_inst", inst_o, 32'h0);
      @(negedge clk);
      rst = 1'b1;

      // Directed table: start-up stream, 5-cycle stall, flush with a response
      // landing in the flush cycle.
      for (int i = 0; i < 21; i++) begin
         tick(vt[i].st, vt[i].fl, vt[i].np, vt[i].g, r, a);
         chk($sformatf("tbl_req[%0d]", i), 32'(r), 32'(vt[i].er));
         if (vt[i].er) chk($sformatf("tbl_addr[%0d]", i), a, vt[i].ea);
         chk($sformatf("tbl_valid[%0d]", i), 32'(inst_valid_o), 32'(vt[i].ev));
         chk($sformatf("tbl_pc[%0d]", i), pc_o, vt[i].ep);
         chk($sformatf("tbl_inst[%0d]", i), inst_o, vt[i].ev ? memf(vt[i].ep) : 32'h0);
      end

      // Flush while two requests are in flight.
      lat_min = 3; lat_max = 3;
      tick(0, 1, 32'h2000, 1, r, a);
      tick(0, 0, 32'h0, 1, r, a);
      tick(0, 0, 32'h0, 1, r, a);
      tick(0, 1, 32'h1003, 1, r, a);
      chk("flush2_valid", 32'(inst_valid_o), 32'h0);
      chk("flush2_inst", inst_o, 32'h0);
      lat_min = 1; lat_max = 1;
      found = 1'b0;
      for (int k = 0; k < 20 && !found; k++) begin
         tick(0, 0, 32'h0, 1, r, a);
         if (inst_valid_o) begin
            found = 1'b1;
            chk("flush2_first_pc", pc_o, 32'h1000);
            chk("flush2_first_inst", inst_o, memf(32'h1000));
         end
      end
      if (!found) timeout("flush2_first_pc");

      // Grant withheld for three cycles at address 0x8, plus a stray rvalid.
      tick(0, 1, 32'h0, 1, r, a);
      held = 0;
      for (int k = 0; k < 30 && held < 3; k++) begin
         want_hold = (exp_fetch == 32'h8);
         spurious  = (held == 1);
         tick(0, 0, 32'h0, !want_hold, r, a);
         if (held > 0) chk("hold_req", 32'(r), 32'h1);
         if (want_hold && r) begin
            chk("hold_addr", a, 32'h8);
            held++;
         end
      end
      if (held < 3) timeout("hold_addr");
      else begin
         chk("drain_valid", 32'(inst_valid_o), 32'h0);
         chk("drain_inst", inst_o, 32'h0);
      end

      // Address wrap-around.
      tick(0, 1, 32'hFFFF_FFF8, 1, r, a);
      got = 0;
      for (int k = 0; k < 30 && got < 3; k++) begin
         tick(0, 0, 32'h0, 1, r, a);
         if (inst_valid_o) begin
            chk($sformatf("wrap_pc[%0d]", got), pc_o, wrap_exp[got]);
            got++;
         end
      end
      if (got < 3) timeout("wrap_pc");

      // Randomized traffic against the reference model.
      lat_min = 1; lat_max = 3; rv_prob = 70;
      for (int k = 0; k < 800; k++) begin
         logic        st, fl, g;
         logic [31:0] np;
         st = ($urandom_range(99) < 20);
         fl = ($urandom_range(99) < 4);
         g  = ($urandom_range(99) < 70);
         np = ($urandom_range(3) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(15))) : $urandom;
         tick(st, fl, np, g, r, a);
      end
      rv_prob = 100;
      for (int k = 0; k < 10; k++) tick(0, 0, 32'h0, 1, r, a);

      $display("Result: errors=%0d of %0d checks", n_err, n_checks);
      $finish;
   end

endmodule
